// File: rtl/btn_pkg.sv
// Shared definitions for the button press classifier: state encoding,
// the event bundle that the FSM registers, and the default timing
// constants for the 100 MHz board clock.
package btn_pkg;

  // 2-bit state encoding; the fourth code is unused and recovers to idle.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PRESSED = 2'd1;
  localparam state_t ST_LONG    = 2'd2;

  // 1 s hold threshold and 200 ms auto-repeat period at 100 MHz.
  localparam int LONG_CYCLES_DEFAULT   = 100_000_000;
  localparam int REPEAT_CYCLES_DEFAULT = 20_000_000;

  // One bit per single-cycle event pulse driven by the classifier.
  typedef struct packed {
    logic press;    // press accepted
    logic rls;      // release accepted
    logic short_p;  // release before the long threshold
    logic long_p;   // hold reached the long threshold
    logic rpt;      // auto-repeat tick while held
  } btn_evt_t;

  localparam btn_evt_t EVT_NONE = '0;

  // True for the two states in which the button counts as held.
  function automatic logic is_held(input state_t st);
    return (st == ST_PRESSED) || (st == ST_LONG);
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Free-running terminal counter used for both the hold timer and the
// auto-repeat timer. Counts 0..TERMINAL-1 while enabled, raises done while
// sitting on TERMINAL-1, and wraps to 0 on the next enabled edge.
module tick_counter #(
  parameter int TERMINAL = 2,
  parameter int WIDTH    = $clog2(TERMINAL + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt;

  // The terminal compare is an equality, so the count can never pass LAST.
  assign done = (cnt == LAST);

  // Count register: clear has priority over enable, wrap on the terminal value.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples the pre-edge values; blocking here would create ordering races.
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= done ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/button_press_classifier.sv
// Button press classifier: converts the clean debounced button level into
// single-cycle press / release / short / long / auto-repeat events plus a
// held level. All outputs come straight from flops.
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic debounced,
  output logic press_tick,
  output logic release_tick,
  output logic short_press,
  output logic long_press,
  output logic repeat_tick,
  output logic held
);

  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  state_t   state_q;
  state_t   state_d;
  btn_evt_t evt_d;
  btn_evt_t evt_q;
  logic     held_q;

  logic hold_clr;
  logic hold_en;
  logic hold_done;
  logic rep_clr;
  logic rep_en;
  logic rep_done;

  // Timers only run while their owning state sees the button still down;
  // outside that state they are held at zero so each entry starts fresh.
  assign hold_clr = (state_q != ST_PRESSED);
  assign hold_en  = (state_q == ST_PRESSED) && debounced;
  assign rep_clr  = (state_q != ST_LONG);
  assign rep_en   = (state_q == ST_LONG) && debounced;

  // Hold timer: done on the edge where the hold reaches LONG_CYCLES.
  tick_counter #(
    .TERMINAL (LONG_CYCLES),
    .WIDTH    (HOLD_W)
  ) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (hold_clr),
    .en    (hold_en),
    .done  (hold_done)
  );

  // Repeat timer: done once every REPEAT_CYCLES edges while in the long hold.
  tick_counter #(
    .TERMINAL (REPEAT_CYCLES),
    .WIDTH    (REP_W)
  ) u_repeat_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (rep_clr),
    .en    (rep_en),
    .done  (rep_done)
  );

  // State and output registers; reset discards any press in progress silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      evt_q   <= EVT_NONE;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      held_q  <= is_held(state_d);
    end
  end

  // Next-state logic: a release always wins over a coincident timer event.
  always_comb begin
    // NOTE: a default assignment before the case keeps every path assigned,
    // so no latch is inferred for combinational outputs.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (debounced) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (!debounced)     state_d = ST_IDLE;
        else if (hold_done) state_d = ST_LONG;
      end
      ST_LONG: begin
        if (!debounced) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Event logic: computes the pulses that the output register will present next cycle.
  always_comb begin
    evt_d = EVT_NONE;
    case (state_q)
      ST_IDLE: begin
        evt_d.press = debounced;
      end
      ST_PRESSED: begin
        if (!debounced) begin
          evt_d.rls     = 1'b1;
          evt_d.short_p = 1'b1;
        end else if (hold_done) begin
          evt_d.long_p = 1'b1;
        end
      end
      ST_LONG: begin
        if (!debounced) begin
          evt_d.rls = 1'b1;
        end else if (rep_done && REPEAT_EN) begin
          evt_d.rpt = 1'b1;
        end
      end
      default: evt_d = EVT_NONE;
    endcase
  end

  assign press_tick   = evt_q.press;
  assign release_tick = evt_q.rls;
  assign short_press  = evt_q.short_p;
  assign long_press   = evt_q.long_p;
  assign repeat_tick  = evt_q.rpt;
  assign held         = held_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier with LONG_CYCLES=8,
// REPEAT_CYCLES=4, REPEAT_EN=1. Every cycle is compared against a model
// that tracks the age of the current press and derives events from it.
module tb_button_press_classifier;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic debounced = 1'b0;
  logic press_tick, release_tick, short_press, long_press, repeat_tick, held;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: whether a press is active, and edges since it was accepted.
  bit m_active = 1'b0;
  int m_age = 0;
  logic e_press, e_rel, e_short, e_long, e_rep, e_held;

  // Observed pulse tallies for the directed scenarios.
  int t_press, t_rel, t_short, t_long, t_rep;

  button_press_classifier #(
    .LONG_CYCLES   (L),
    .REPEAT_CYCLES (R),
    .REPEAT_EN     (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .debounced    (debounced),
    .press_tick   (press_tick),
    .release_tick (release_tick),
    .short_press  (short_press),
    .long_press   (long_press),
    .repeat_tick  (repeat_tick),
    .held         (held)
  );

  always #5 clk = ~clk;

  task automatic model(input logic r, input logic d);
    e_press = 1'b0; e_rel = 1'b0; e_short = 1'b0; e_long = 1'b0; e_rep = 1'b0;
    if (r) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (d) begin
        m_active = 1'b1;
        m_age    = 0;
        e_press  = 1'b1;
      end
    end else begin
      m_age = m_age + 1;
      if (!d) begin
        e_rel    = 1'b1;
        e_short  = (m_age <= L);
        m_active = 1'b0;
      end else if (m_age == L) begin
        e_long = 1'b1;
      end else if (m_age > L && ((m_age - L) % R) == 0) begin
        e_rep = 1'b1;
      end
    end
    e_held = m_active;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_tally();
    t_press = 0; t_rel = 0; t_short = 0; t_long = 0; t_rep = 0;
  endtask

  task automatic check_tally(input string tag, input int p, input int rl,
                             input int s, input int lg, input int rp);
    check_int({tag, ".press"},   t_press, p);
    check_int({tag, ".release"}, t_rel,   rl);
    check_int({tag, ".short"},   t_short, s);
    check_int({tag, ".long"},    t_long,  lg);
    check_int({tag, ".repeat"},  t_rep,   rp);
  endtask

  // One clock: drive on the falling edge, compare 1 ns after the rising edge.
  task automatic step(input logic r, input logic d);
    @(negedge clk);
    reset     = r;
    debounced = d;
    @(posedge clk);
    cyc++;
    model(r, d);
    #1;
    check("press_tick",   press_tick,   e_press);
    check("release_tick", release_tick, e_rel);
    check("short_press",  short_press,  e_short);
    check("long_press",   long_press,   e_long);
    check("repeat_tick",  repeat_tick,  e_rep);
    check("held",         held,         e_held);
    t_press += int'(press_tick);
    t_rel   += int'(release_tick);
    t_short += int'(short_press);
    t_long  += int'(long_press);
    t_rep   += int'(repeat_tick);
  endtask

  task automatic pulse(input int hi, input int lo);
    for (int j = 0; j < hi; j++) step(1'b0, 1'b1);
    for (int j = 0; j < lo; j++) step(1'b0, 1'b0);
  endtask

  initial begin
    int  hi;
    int  lo;
    int  rs_at;

    // 1. Reset with the button held: outputs stay low, press on first free edge.
    clear_tally();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check_tally("reset_hold", 0, 0, 0, 0, 0);
    pulse(1, 0);
    check_tally("press_after_reset", 1, 0, 0, 0, 0);
    pulse(0, 3);

    // 2. Three-cycle press: short press, no long press.
    clear_tally();
    pulse(3, 3);
    check_tally("short3", 1, 1, 1, 0, 0);

    // 3. Twenty-cycle hold: long press, two repeats, release wins over third repeat.
    clear_tally();
    pulse(20, 3);
    check_tally("hold20", 1, 1, 0, 1, 2);

    // 4. Release exactly on the threshold edge: short wins, no long press.
    clear_tally();
    pulse(L, 3);
    check_tally("threshold", 1, 1, 1, 0, 0);

    // 5. Single-cycle pulses back to back.
    clear_tally();
    pulse(1, 1);
    pulse(1, 3);
    check_tally("back2back", 2, 2, 2, 0, 0);

    // 6. Reset during the long hold, then a fresh press counts from zero.
    clear_tally();
    pulse(12, 0);
    step(1'b1, 1'b1);
    check("reset_mid_hold.held", held, 1'b0);
    pulse(L + 1, 3);
    check_tally("reset_long", 2, 1, 0, 2, 0);

    // Randomized holds of varied length with occasional resets mid-hold.
    for (int i = 0; i < 250; i++) begin
      hi    = int'($urandom_range(1, 24));
      lo    = int'($urandom_range(1, 3));
      rs_at = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, hi - 1)) : -1;
      for (int j = 0; j < hi; j++) step((j == rs_at) ? 1'b1 : 1'b0, 1'b1);
      for (int j = 0; j < lo; j++) step(1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
